// File: rtl/rr_count_arbiter.sv
// Round-robin arbiter for one single-owner resource: grants are held until release,
// request drop, or a programmable hold limit, with same-edge re-arbitration.
module rr_count_arbiter #(
  parameter int NUM_REQ    = 8,
  parameter int IDX_WIDTH  = 3,
  parameter int HOLD_WIDTH = 4,
  parameter int MAX_HOLD   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   i__req,
  input  logic                 i__release,
  output logic [NUM_REQ-1:0]   o__grant,
  output logic                 o__grant__valid,
  output logic [IDX_WIDTH-1:0] o__grant__idx,
  output logic                 o__timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [HOLD_WIDTH-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : HOLD_WIDTH'(MAX_HOLD - 1);

  state_t                 state, state_nxt;
  logic [IDX_WIDTH-1:0]   r__ptr;
  logic [IDX_WIDTH-1:0]   idx_q;
  logic [HOLD_WIDTH-1:0]  hold_q;
  logic [NUM_REQ-1:0]     grant_q;
  logic                   timeout_q;

  logic                   win_vld;
  logic [IDX_WIDTH-1:0]   win_idx;
  logic [IDX_WIDTH-1:0]   cand;
  logic                   end_rel, end_to, grant_end, take;

  // Scan from the highest offset down so the smallest offset from r__ptr wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = r__ptr;
    cand    = r__ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = r__ptr + IDX_WIDTH'(k);
      if (i__req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign end_rel   = i__release | ~i__req[idx_q];
  assign end_to    = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
  assign grant_end = (state == BUSY) && (end_rel || end_to);
  assign take      = win_vld && ((state == IDLE) || grant_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = win_vld ? BUSY : IDLE;
      BUSY:    if (grant_end) state_nxt = win_vld ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r__ptr    <= '0;
      idx_q     <= '0;
      hold_q    <= '0;
      grant_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      // A simultaneous release/drop takes precedence over the hold limit.
      timeout_q <= (state == BUSY) && end_to && !end_rel;
      if (take) begin
        idx_q   <= win_idx;
        r__ptr  <= win_idx + IDX_WIDTH'(1);
        hold_q  <= '0;
        grant_q <= NUM_REQ'(1) << win_idx;
      end else if ((state == IDLE) || grant_end) begin
        grant_q <= '0;
      end else if (hold_q != '1) begin
        hold_q  <= hold_q + HOLD_WIDTH'(1);
      end
    end
  end

  always_comb begin
    o__grant        = grant_q;
    o__grant__valid = (state == BUSY);
    o__grant__idx   = idx_q;
    o__timeout      = timeout_q;
  end

endmodule

// File: tb/tb_rr_count_arbiter.sv
// Directed and random stimulus for rr_count_arbiter, checked cycle by cycle
// against an integer-level model of the round-robin hold/timeout rules.
module tb_rr_count_arbiter;
  localparam int N  = 8;
  localparam int MH = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] i__req = '0;
  logic         i__release = 1'b0;
  logic [N-1:0] o__grant;
  logic         o__grant__valid;
  logic [2:0]   o__grant__idx;
  logic         o__timeout;

  int n_pass = 0;
  int n_total = 0;

  bit m_vld;
  int m_idx, m_ptr, m_hold;
  bit m_to;

  rr_count_arbiter #(.NUM_REQ(N), .IDX_WIDTH(3), .HOLD_WIDTH(4), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .i__req(i__req), .i__release(i__release),
    .o__grant(o__grant), .o__grant__valid(o__grant__valid),
    .o__grant__idx(o__grant__idx), .o__timeout(o__timeout));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int pick(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++)
      if (r[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_vld = 0; m_idx = 0; m_ptr = 0; m_hold = 0; m_to = 0;
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] eg;
    eg = m_vld ? (N'(1) << m_idx) : '0;
    chk({tag, ".grant"}, 16'(o__grant), 16'(eg));
    chk({tag, ".valid"}, 16'(o__grant__valid), 16'(m_vld));
    chk({tag, ".idx"}, 16'(o__grant__idx), 16'(m_idx));
    chk({tag, ".timeout"}, 16'(o__timeout), 16'(m_to));
  endtask

  // Drive inputs, advance the model over the coming edge, then compare.
  task automatic cycle(input logic [N-1:0] req, input logic rel, input string tag);
    int w;
    bit rel_end, to_end;
    i__req = req;
    i__release = rel;
    m_to = 0;
    if (!m_vld) begin
      w = pick(req, m_ptr);
      if (w >= 0) begin m_vld = 1; m_idx = w; m_ptr = (w + 1) % N; m_hold = 0; end
    end else begin
      rel_end = rel || !req[m_idx];
      to_end  = (MH != 0) && (m_hold == MH - 1);
      if (rel_end || to_end) begin
        m_to = to_end && !rel_end;
        w = pick(req, m_ptr);
        if (w >= 0) begin m_idx = w; m_ptr = (w + 1) % N; m_hold = 0; end
        else m_vld = 0;
      end else if (m_hold < 15) begin
        m_hold++;
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i__req = '0;
    i__release = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] r;
    model_reset();

    // Reset state and single request
    do_reset();
    cycle(8'b0000_0100, 1'b0, "single2");
    chk("single2.idx_is_2", 16'(o__grant__idx), 16'd2);
    cycle(8'b0000_0000, 1'b0, "drop2");

    // All requesting, release on every owner's second cycle
    do_reset();
    for (int i = 0; i < 20; i++)
      cycle(8'hFF, (m_vld && m_hold == 1), "rotate");

    // Two requesters, timeout ping-pong
    do_reset();
    for (int i = 0; i < 20; i++) cycle(8'b1000_0001, 1'b0, "timeout");

    // Sole requester re-granted back to back
    do_reset();
    cycle(8'b0010_0000, 1'b0, "sole5");
    for (int i = 0; i < 4; i++) cycle(8'b0010_0000, 1'b1, "sole5rel");

    // Owner drops its request
    do_reset();
    cycle(8'b0000_1000, 1'b0, "own3");
    cycle(8'b0000_1000, 1'b0, "own3");
    cycle(8'b0000_0000, 1'b0, "own3drop");
    cycle(8'b0000_0000, 1'b1, "idlerel");

    // Reset asserted mid-grant
    do_reset();
    cycle(8'b0100_0000, 1'b0, "own6");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    cycle(8'b0100_0010, 1'b0, "after_reset");
    chk("after_reset.idx_is_1", 16'(o__grant__idx), 16'd1);

    // Random traffic
    do_reset();
    r = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom & $urandom);
      cycle(r, ($urandom_range(0, 5) == 0), "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/rr_count_arbiter.md
Name: rr_count_arbiter

Overview:
- Round-robin arbiter that shares one single-owner resource among NUM_REQ requesters. Typical resources are a shared wrap-around event counter or a shared increment port.
- Holds each grant until the owner releases it, drops its request, or exceeds a programmable hold limit.
- The rotating priority pointer is a wrap-around counter.
- Sits between requesting pipeline stages and the shared resource; o__grant__idx drives the resource's input select.

Parameters:
- NUM_REQ, 8, number of requesters; power of two, 2..16.
- IDX_WIDTH, 3, width of the requester index; equals log2(NUM_REQ).
- HOLD_WIDTH, 4, width of the hold-cycle counter.
- MAX_HOLD, 8, maximum cycles a grant is held; 0 disables the timeout. Must be less than 2^HOLD_WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i__req  input  NUM_REQ  request vector; bit k = requester k wants the resource.
- i__release  input  1  current owner frees the resource this cycle.
- o__grant  output  NUM_REQ  one-hot grant, registered; all zero when idle.
- o__grant__valid  output  1  a grant is active.
- o__grant__idx  output  IDX_WIDTH  index of the current owner; holds its last value when not valid.
- o__timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Behaviour:
- Reset (async assert, sync deassert on clk):
  - o__grant = 0, o__grant__valid = 0, o__grant__idx = 0, o__timeout = 0.
  - Pointer r__ptr = 0, hold counter = 0, FSM = IDLE.
- FSM states: IDLE and BUSY.
- Winner selection (combinational):
  - Scan i__req cyclically starting at r__ptr.
  - The first set bit wins, i.e. highest priority is at r__ptr, lowest at r__ptr-1 mod NUM_REQ.
- IDLE:
  - If any i__req bit is set, the registered grant for the winner appears the next cycle (1-cycle latency).
  - On that edge: FSM -> BUSY, hold counter -> 0, r__ptr -> winner+1, wrapping from NUM_REQ-1 to 0.
  - If no request, stay in IDLE with outputs unchanged except valid = 0.
- BUSY: the grant ends at the end of a cycle in which any of these holds:
  - (a) i__release = 1;
  - (b) i__req[o__grant__idx] = 0;
  - (c) MAX_HOLD != 0 and hold counter == MAX_HOLD-1.
- BUSY, otherwise: the grant holds and the hold counter increments by 1, saturating at its maximum.
- At grant end, re-arbitrate in the same cycle:
  - Use the pointer already advanced past the owner.
  - If a winner exists, the new grant is registered at that edge; there is no bubble cycle.
  - Otherwise FSM -> IDLE and grant/valid clear next cycle.
- The ending owner is lowest priority. It is re-granted only if it is the sole requester.
- o__timeout:
  - Asserts for exactly the cycle after a type (c) end.
  - If (a) or (b) coincides with (c), the end counts as release and o__timeout stays 0.
- i__release while IDLE is ignored.
- Requests appearing mid-grant wait; there is no preemption except timeout.
- o__grant is always zero or one-hot and agrees with o__grant__idx whenever valid = 1.
- Reset asserted mid-grant clears all state immediately. After deassert, arbitration restarts from r__ptr = 0.

Test Plan:
- Reset then i__req=8'b0000_0100 → next cycle o__grant=8'b0000_0100, idx=2, valid=1. Pointer becomes 3.
- i__req=8'hFF held, i__release pulsed every 2nd granted cycle → grants rotate idx 0,1,2,...,7,0, each held 2 cycles, no idle cycles between grants.
- i__req=8'b1000_0001, ptr=0, no release, MAX_HOLD=8 → idx 0 held 8 cycles, then o__timeout=1 for one cycle and idx 7 granted. The next timeout returns the grant to idx 0.
- Single requester idx 5 releases and keeps requesting → re-granted back-to-back (valid stays 1), o__timeout=0.
- Owner idx 3 drops i__req with no other requests → valid=0 next cycle, FSM IDLE, idx stays 3.
- rst_n low during a grant to idx 6 → grant/valid drop immediately. After release with i__req=8'b0100_0010, grant idx 1 (ptr=0).
